// File: rtl/muldiv_unit.sv
// muldiv_unit: shared multiply / divide unit for a CPU pipeline.
//   Multiply: full 2*WIDTH-bit product (signed or unsigned), MUL_STAGES-cycle latency.
//   Divide:   radix-2 restoring division on operand magnitudes, one quotient bit per
//             cycle, followed by one sign-correction cycle. A zero divisor takes an
//             early-out path (hi = a, lo = all ones, div_by_zero = 1).
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       request an operation (sampled only in IDLE)
//   op          0 = multiply, 1 = divide
//   is_signed   1 = two's-complement operands
//   cancel      abort the operation in flight
//   a, b        operands (multiplicand/dividend, multiplier/divisor)
//   busy        high while multiplying or dividing
//   done        one-cycle pulse; hi/lo/div_by_zero valid in that cycle
//   hi, lo      product upper/lower half, or remainder/quotient
//   div_by_zero qualifies the current result: last divide had b = 0
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 2);
    // Registered multiply stages before the result registers; the result
    // registers themselves form the final stage.
    localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic [WIDTH-1:0]   quo_q;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] pipe_q [PD];
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dbz_q;

    logic               accept;
    logic               div_step;
    logic               res_we;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_dbz;

    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_c, mul_res;
    logic [WIDTH:0]     shift_c, trial_c;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;

    assign accept = (state_q == IDLE) && start && !cancel;

    assign a_mag_in = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag_in = (is_signed && b[WIDTH-1]) ? -b : b;

    // ---------------- multiply datapath ----------------
    assign a_neg  = sgn_q & a_q[WIDTH-1];
    assign b_neg  = sgn_q & b_q[WIDTH-1];
    assign a_ext  = {{WIDTH{a_neg}}, a_q};
    assign b_ext  = {{WIDTH{b_neg}}, b_q};
    assign prod_c = a_ext * b_ext;

    generate
        if (MUL_STAGES == 1) begin : g_mul_direct
            assign mul_res = prod_c;
        end else begin : g_mul_piped
            assign mul_res = pipe_q[PD-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PD; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= prod_c;
            for (int unsigned i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // ---------------- divide datapath ----------------
    assign shift_c = {rem_q, quo_q[WIDTH-1]};
    assign trial_c = shift_c - {1'b0, dvs_q};
    assign q_fix   = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
    assign r_fix   = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        div_step = 1'b0;
        res_we   = 1'b0;
        res_hi   = hi_q;
        res_lo   = lo_q;
        res_dbz  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = op ? DIV : MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(MUL_STAGES - 1)) begin
                    state_d = DONE;
                    res_we  = 1'b1;
                    res_hi  = mul_res[2*WIDTH-1:WIDTH];
                    res_lo  = mul_res[WIDTH-1:0];
                end
            end
            DIV: begin
                busy = 1'b1;
                if (cancel) begin
                    state_d = IDLE;
                end else if (b_q == '0) begin
                    state_d = DONE;
                    res_we  = 1'b1;
                    res_hi  = a_q;
                    res_lo  = '1;
                    res_dbz = 1'b1;
                end else if (cnt_q == CW'(WIDTH)) begin
                    // sign-correction cycle after the last quotient bit
                    state_d = DONE;
                    res_we  = 1'b1;
                    res_hi  = r_fix;
                    res_lo  = q_fix;
                end else begin
                    div_step = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= is_signed;
            dvs_q <= b_mag_in;
            quo_q <= a_mag_in;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
            if (div_step) begin
                if (!trial_c[WIDTH]) begin
                    rem_q <= trial_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shift_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else if (res_we) begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            dbz_q <= res_dbz;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, MUL_STAGES=2): the driver pushes the
// hand-computed result and expected done cycle; the monitor pops on every done.
module tb_muldiv_unit;

    logic        clk, rst, start, op, is_signed, cancel;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int seen  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .is_signed(is_signed),
        .cancel(cancel), .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"},  64'(hi), 64'(e.hi));
                chk({e.name, "_lo"},  64'(lo), 64'(e.lo));
                chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                chk({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
            seen++;
        end
    end

    // call at a negedge; returns at the negedge of the cycle after done
    task automatic issue(input string nm, input bit o, input bit sg,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] eh, input logic [31:0] el,
                         input bit ed, input int lat);
        int  s, n0, c;
        bit  got;
        exp_t e;
        s  = cyc;
        n0 = seen;
        e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = s + lat; e.name = nm;
        sb.push_back(e);
        op = o; is_signed = sg; a = aa; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;   // operands must not be re-sampled
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            c = cyc - s;
            if (seen != n0) got = 1'b1;
            else if (c == 1 || c == lat - 1) chk({nm, "_busy"}, 64'(busy), 64'd1);
            if (!got) @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done by cycle %0d", nm, s + lat);
            sb.delete();
        end else begin
            chk({nm, "_busy_done"}, 64'(busy), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int s;
        rst = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; cancel = 1'b0;
        a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_dbz",  64'(div_by_zero), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // start on the first edge after reset release, then back-to-back ops
        issue("mul_s_neg3x5", 0, 1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 3);
        issue("mul_u_max",    0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 3);
        issue("mul_s_minmin", 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 3);
        issue("div_u_100_7",  1, 0, 32'd100,       32'd7,         32'd2,         32'd14,        0, 34);
        issue("div_s_m7_2",   1, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
        issue("div_s_min_m1", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 34);
        issue("div_zero",     1, 0, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1, 2);
        issue("div_s_7_m2",   1, 1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 34);
        issue("div_s_zero",   1, 1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 2);
        issue("div_u_big",    1, 0, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 0, 34);

        // cancel a divide in cycle 10; results keep the previous values
        s = cyc;
        op = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("cancel_busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_cyc",  64'(cyc - s), 64'd11);
        chk("cancel_hi",   64'(hi), 64'd1);
        chk("cancel_lo",   64'(lo), 64'h7FFF_FFFC);
        issue("mul_after_cancel", 0, 0, 32'd6, 32'd7, 32'd0, 32'd42, 0, 3);

        // cancel and start together in IDLE: start is dropped
        op = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        chk("start_cancel_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("start_cancel_lo", 64'(lo), 64'd42);

        // asynchronous reset in cycle 5 of a divide
        op = 1'b1; is_signed = 1'b0; a = 32'd500; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi",   64'(hi),   64'd0);
        chk("arst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        issue("mul_after_rst", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 3);
        repeat (40) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
